// File: rtl/cmd_message_printer.sv
// rtl/cmd_message_printer.sv - prints canned message i on rx command CMD_BASE+i, echoes other bytes
module cmd_message_printer #(
  parameter int                           NUM_MSG  = 4,
  parameter int                           MAX_LEN  = 16,
  parameter logic [7:0]                   CMD_BASE = 8'h30,
  parameter logic [7:0]                   TERM     = 8'h00,
  parameter bit                           ECHO     = 1'b1,
  parameter logic [NUM_MSG*MAX_LEN*8-1:0] MSG_DATA = {
    128'h0,
    128'h0000_0000_0000_0000_0000_0000_0A0D_4B4F,
    128'h0000_0A0D_2164_6C72_6F57_206F_6C6C_6548,
    128'h0000_0000_0000_0000_0000_0000_0A0D_6948
  }
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic       busy,
  output logic [3:0] cur_msg,
  output logic [7:0] drop_cnt
);

  localparam int              IW   = $clog2(MAX_LEN + 1);
  localparam logic [IW-1:0]   LAST = IW'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, SEND, ECHO_ST, GAP, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [7:0]    tx_data_nxt, echo_byte, echo_byte_nxt, drop_cnt_nxt;
  logic          new_tx_nxt, is_echo, is_echo_nxt, pend_valid, pend_valid_nxt;
  logic [3:0]    pend_idx, pend_idx_nxt, cur_msg_nxt;
  logic [7:0]    rx_off, msg_byte;
  logic [3:0]    rx_idx;
  logic          rx_cmd;

  // Range check is plain unsigned, so a base near 8'hFF never wraps into low bytes
  assign rx_off = rx_data - CMD_BASE;
  assign rx_idx = rx_off[3:0];
  assign rx_cmd = (rx_data >= CMD_BASE) && (rx_off < 8'(NUM_MSG));
  assign busy   = (state != IDLE);

  always_comb begin
    msg_byte = TERM;
    for (int i = 0; i < NUM_MSG; i++) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if (cur_msg == i[3:0] && idx == j[IW-1:0]) begin
          msg_byte = MSG_DATA[(i*MAX_LEN+j)*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    tx_data_nxt    = tx_data;
    new_tx_nxt     = 1'b0;
    cur_msg_nxt    = cur_msg;
    echo_byte_nxt  = echo_byte;
    is_echo_nxt    = is_echo;
    pend_valid_nxt = pend_valid;
    pend_idx_nxt   = pend_idx;
    drop_cnt_nxt   = drop_cnt;

    if (state != IDLE && new_rx_data && rx_cmd) begin
      if (!pend_valid) begin
        pend_valid_nxt = 1'b1;
        pend_idx_nxt   = rx_idx;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt_nxt = drop_cnt + 8'd1;
      end
    end

    case (state)
      IDLE: begin
        if (pend_valid) begin
          // The slot is freed this cycle, so a same-cycle command refills it
          cur_msg_nxt    = pend_idx;
          idx_nxt        = '0;
          is_echo_nxt    = 1'b0;
          state_nxt      = SEND;
          pend_valid_nxt = new_rx_data && rx_cmd;
          pend_idx_nxt   = rx_idx;
        end else if (new_rx_data && rx_cmd) begin
          cur_msg_nxt = rx_idx;
          idx_nxt     = '0;
          is_echo_nxt = 1'b0;
          state_nxt   = SEND;
        end else if (new_rx_data && ECHO) begin
          echo_byte_nxt = rx_data;
          is_echo_nxt   = 1'b1;
          state_nxt     = ECHO_ST;
        end
      end
      SEND: begin
        if (idx == LAST || msg_byte == TERM) begin
          state_nxt = DONE;
        end else if (!tx_busy) begin
          tx_data_nxt = msg_byte;
          new_tx_nxt  = 1'b1;
          idx_nxt     = idx + IW'(1);
          state_nxt   = GAP;
        end
      end
      ECHO_ST: begin
        if (!tx_busy) begin
          tx_data_nxt = echo_byte;
          new_tx_nxt  = 1'b1;
          state_nxt   = GAP;
        end
      end
      GAP:     state_nxt = is_echo ? DONE : SEND;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
      cur_msg     <= '0;
      echo_byte   <= '0;
      is_echo     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_idx    <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      tx_data     <= tx_data_nxt;
      new_tx_data <= new_tx_nxt;
      cur_msg     <= cur_msg_nxt;
      echo_byte   <= echo_byte_nxt;
      is_echo     <= is_echo_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_idx    <= pend_idx_nxt;
      drop_cnt    <= drop_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_message_printer.sv
// tb/tb_cmd_message_printer.sv - random and directed bench for cmd_message_printer
module tb_cmd_message_printer;

  localparam int         NUM  = 4;
  localparam int         MLEN = 16;
  localparam logic [7:0] BASE = 8'h30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       new_rx_data = 1'b0;
  logic       busy;
  logic [3:0] cur_msg;
  logic [7:0] drop_cnt;

  cmd_message_printer dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .new_tx_data(new_tx_data),
    .tx_busy(tx_busy), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .busy(busy), .cur_msg(cur_msg), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a print job is a byte queue; each byte needs a ready cycle with
  // tx_busy low, then one idle cycle; an exhausted message costs one check
  // cycle plus one closing cycle, an echo two closing cycles after its byte.
  string      msg_str [NUM] = '{"Hi\r\n", "Hello World!\r\n", "OK\r\n", ""};
  logic [7:0] m_q[$];
  bit         m_active, m_echo, m_stb;
  int         m_cd, m_tail, m_pend, m_cur, m_drop;
  logic [7:0] m_txd;

  function automatic bit is_cmd(input logic [7:0] b);
    return (int'(b) >= int'(BASE)) && (int'(b) < int'(BASE) + NUM);
  endfunction

  task start_msg(input int m);
    m_q.delete();
    for (int j = 0; j < MLEN && j < msg_str[m].len(); j++) m_q.push_back(msg_str[m][j]);
    m_cur = m; m_echo = 0; m_cd = 0; m_tail = 0; m_active = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete(); m_active = 0; m_echo = 0; m_stb = 0; m_cd = 0; m_tail = 0;
      m_pend = -1; m_cur = 0; m_drop = 0; m_txd = 8'h00;
    end else begin
      m_stb = 0;
      if (m_active) begin
        if (new_rx_data && is_cmd(rx_data)) begin
          if (m_pend < 0) m_pend = int'(rx_data) - int'(BASE);
          else if (m_drop < 255) m_drop++;
        end
        if (m_tail > 0) begin
          m_tail--;
          if (m_tail == 0) m_active = 0;
        end else if (m_cd > 0) m_cd--;
        else if (m_q.size() == 0) m_tail = 1;
        else if (!tx_busy) begin
          m_txd = m_q.pop_front();
          m_stb = 1;
          if (m_echo) m_tail = 2; else m_cd = 1;
        end
      end else if (m_pend >= 0) begin
        start_msg(m_pend);
        m_pend = (new_rx_data && is_cmd(rx_data)) ? int'(rx_data) - int'(BASE) : -1;
      end else if (new_rx_data && is_cmd(rx_data)) begin
        start_msg(int'(rx_data) - int'(BASE));
      end else if (new_rx_data) begin
        m_q.delete(); m_q.push_back(rx_data);
        m_echo = 1; m_cd = 0; m_tail = 0; m_active = 1;
      end
    end
  end

  logic [7:0] got_q[$];
  int  cyc = 0, first_stb = -1, busy_mode = 0, sbusy = 0, n_busy = 0;
  bit  prev_stb = 0;

  // One clock: drive inputs, let the edge pass, compare on the falling edge
  task automatic cycle(input logic rxv, input logic [7:0] rxd);
    new_rx_data = rxv; rx_data = rxd;
    if (busy_mode == 1) tx_busy = (sbusy > 0);
    else if (busy_mode == 2) tx_busy = ($urandom_range(0, 3) == 0);
    else tx_busy = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (sbusy > 0) sbusy--;
    check("strobe", new_tx_data, m_stb);
    check("tx_data", tx_data, m_txd);
    check("busy", busy, m_active);
    check("cur_msg", cur_msg, m_cur);
    check("drop_cnt", drop_cnt, m_drop);
    if (prev_stb) check("no_back_to_back", new_tx_data, 1'b0);
    if (busy) n_busy++;
    if (new_tx_data) begin
      got_q.push_back(tx_data);
      if (first_stb < 0) first_stb = cyc;
      sbusy = 10;
    end
    prev_stb = new_tx_data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic expect_str(input string tag, input string s);
    check({tag, "_len"}, got_q.size(), s.len());
    for (int i = 0; i < s.len() && i < got_q.size(); i++) check(tag, got_q[i], s[i]);
  endtask

  task automatic fresh();
    got_q.delete(); first_stb = -1; n_busy = 0;
  endtask

  int rx_cyc, saved;

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    fresh();
    idle(20);
    check("idle_no_strobes", got_q.size(), 0);

    fresh(); rx_cyc = cyc;
    cycle(1'b1, 8'h31); idle(40);
    expect_str("msg1", "Hello World!\r\n");
    check("msg1_latency", first_stb - rx_cyc, 2);
    check("msg1_cur", cur_msg, 4'd1);

    fresh(); busy_mode = 1;
    cycle(1'b1, 8'h31); idle(250);
    expect_str("msg1_slow", "Hello World!\r\n");
    busy_mode = 0;

    fresh();
    cycle(1'b1, 8'h41); idle(10);
    expect_str("echo", "A");

    fresh();
    cycle(1'b1, 8'h33); idle(10);
    check("empty_busy_cycles", n_busy, 2);
    check("empty_no_strobe", got_q.size(), 0);

    fresh();
    cycle(1'b1, 8'h31); idle(6);
    cycle(1'b1, 8'h30); idle(4);
    cycle(1'b1, 8'h32); idle(80);
    expect_str("pend", "Hello World!\r\nHi\r\n");
    check("pend_drop", drop_cnt, 8'd1);

    fresh();
    cycle(1'b1, 8'h31);
    for (int i = 0; i < 200 && got_q.size() < 5; i++) cycle(1'b0, 8'h00);
    check("mid_reset_wait", got_q.size(), 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx_data", tx_data, 8'h00);
    check("async_busy", busy, 1'b0);
    check("async_drop", drop_cnt, 8'h00);
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    saved = got_q.size();
    idle(40);
    check("no_resume", got_q.size(), saved);

    busy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 1) cycle(1'b1, 8'(8'h2E + $urandom_range(0, 7)));
        else cycle(1'b1, 8'($urandom_range(0, 255)));
      end else begin
        cycle(1'b0, 8'h00);
      end
    end
    busy_mode = 0;
    idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
